// File: rtl/clk_gen_pkg.sv
// Shared types and defaults for the clk_enable_gen slice (lock FSM states, default widths).
// Optional feature macro used by this slice: CE_SYNC_EN.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        COUNTING,
        LOCKED
    } lock_state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int LOCK_CYCLES_DEF = 1024;

    // Channel-select width never drops below one bit, even for a single channel.
    function automatic int ch_sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ce_div_channel.sv
// One clock-enable divider channel: counter, shadow divide register, live divide register, busy flag.
// With CE_SYNC_EN defined, a sync input phase-aligns the counter to zero.
module ce_div_channel
    import clk_gen_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DIV_INIT = 0
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr,
    input  logic [CNT_W-1:0] val,
`ifdef CE_SYNC_EN
    input  logic             sync,
`endif
    output logic             ce_o,
    output logic             busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             busy_q, busy_d;
    logic             sync_hit;
    logic             terminal;
    logic             boundary;

`ifdef CE_SYNC_EN
    assign sync_hit = run && sync;
`else
    assign sync_hit = 1'b0;
`endif

    assign terminal = run && !sync_hit && (cnt_q == div_q);
    assign boundary = !run || sync_hit || terminal;

    // A pending divide is committed only on a period boundary (or while idle), so no runt period appears.
    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        if (boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (busy_q && boundary) begin
            div_d  = shadow_q;
            busy_d = 1'b0;
        end
        if (wr) begin
            shadow_d = val;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_q    <= CNT_W'(DIV_INIT);
            shadow_q <= CNT_W'(DIV_INIT);
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
        end
    end

    assign ce_o   = terminal;
    assign busy_o = busy_q;

endmodule

// File: rtl/clk_enable_gen.sv
// PLL lock qualifier and NUM_CH programmable clock-enable generator running on clkin.
// Define CE_SYNC_EN to add the sync_req input that phase-aligns all channels.
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = CNT_W_DEF,
    parameter int  DIV_INIT    = 0,
    parameter int  LOCK_CYCLES = LOCK_CYCLES_DEF,
    localparam int CH_W        = ch_sel_width(NUM_CH)
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
`ifdef CE_SYNC_EN
    input  logic              sync_req,
`endif
    output logic              locked,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] div_busy
);

    localparam int              LC_W      = $clog2(LOCK_CYCLES + 1);
    localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

    logic            lk_meta_q;
    logic            lk_s_q;
    lock_state_t     state_q;
    logic [LC_W-1:0] lock_cnt_q;
    logic            locked_q;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_s_q    <= lk_meta_q;
        end
    end

    // The first synced-high cycle is seen in UNLOCKED, so COUNTING starts at 1 to keep rise latency at LOCK_CYCLES+2.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                UNLOCKED: begin
                    lock_cnt_q <= '0;
                    locked_q   <= 1'b0;
                    if (lk_s_q) begin
                        if (LOCK_CYCLES == 1) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q    <= COUNTING;
                            lock_cnt_q <= LC_W'(1);
                        end
                    end
                end
                COUNTING: begin
                    if (!lk_s_q) begin
                        state_q    <= UNLOCKED;
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LC_W'(1);
                    end
                end
                LOCKED: begin
                    if (!lk_s_q) begin
                        state_q    <= UNLOCKED;
                        lock_cnt_q <= '0;
                        locked_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= UNLOCKED;
                    lock_cnt_q <= '0;
                    locked_q   <= 1'b0;
                end
            endcase
        end
    end

    assign locked = locked_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ce_div_channel #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clkin  (clkin),
            .rst_n  (rst_n),
            .run    (locked_q),
            .wr     (div_wr && (div_ch == CH_W'(g))),
            .val    (div_val),
`ifdef CE_SYNC_EN
            .sync   (sync_req),
`endif
            .ce_o   (ce_out[g]),
            .busy_o (div_busy[g])
        );
    end

endmodule
